// File: rtl/game_mode_ctrl.sv
// Frame-synchronous game sequencer: START / INGAME / GAMEOVER modes, lives, score and invulnerability.
// Define GAME_PAUSE_EN to add a PAUSE state (right click toggles it) and the paused output.
module game_mode_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int INVULN_FRAMES  = 60,
    parameter int GO_HOLD_FRAMES = 120,
    parameter int SCORE_W        = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               leftButton,
    input  logic               rightButton,
    input  logic               hit,
    input  logic               eat,
    output logic               start_signal,
    output logic               ingame_signal,
    output logic               gameover_signal,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               invuln
`ifdef GAME_PAUSE_EN
    ,
    output logic               paused
`endif
);

    localparam logic [2:0] LIVES_LD = 3'(LIVES_INIT);
    localparam logic [7:0] INV_LD   = 8'(INVULN_FRAMES);
    localparam logic [7:0] HOLD_LD  = 8'(GO_HOLD_FRAMES);

    localparam int IDX_FRAME = 0;
    localparam int IDX_LEFT  = 1;
    localparam int IDX_HIT   = 2;
    localparam int IDX_EAT   = 3;
`ifdef GAME_PAUSE_EN
    localparam int IDX_RIGHT = 4;
    localparam int N_IN      = 5;
`else
    localparam int N_IN      = 4;
`endif

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_INGAME   = 2'd1,
        ST_GAMEOVER = 2'd2
`ifdef GAME_PAUSE_EN
        ,
        ST_PAUSE    = 2'd3
`endif
    } state_t;

    state_t            state, state_d;
    logic [N_IN-1:0]   async_in, sync1, sync2, sync_prev, pulse;
    logic              frame_tick, lclick, hit_p, eat_p;
    logic              click_pend, hit_pend, pause_req;
    logic [7:0]        inv_cnt, hold_cnt;
    logic              start_d, ingame_d, gameover_d;

`ifdef GAME_PAUSE_EN
    logic              rclick_pend;
    logic              paused_d;

    assign async_in  = {rightButton, eat, hit, leftButton, frame_clk};
    assign pause_req = rclick_pend;
`else
    logic              unused_right_button;

    assign async_in            = {eat, hit, leftButton, frame_clk};
    assign pause_req           = 1'b0;
    assign unused_right_button = rightButton;
`endif

    // Two-flop synchronizers followed by a registered rising-edge detector per input.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            pulse     <= '0;
        end else begin
            sync1     <= async_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            pulse     <= sync2 & ~sync_prev;
        end
    end

    assign frame_tick = pulse[IDX_FRAME];
    assign lclick     = pulse[IDX_LEFT];
    assign hit_p      = pulse[IDX_HIT];
    assign eat_p      = pulse[IDX_EAT];

    // Sticky event latches: a new event wins over the frame-tick clear and carries to the next frame.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            click_pend <= 1'b0;
            hit_pend   <= 1'b0;
        end else begin
            if (state == ST_GAMEOVER && hold_cnt != 8'd0) click_pend <= 1'b0;
            else if (lclick)                              click_pend <= 1'b1;
            else if (frame_tick)                          click_pend <= 1'b0;

            if (hit_p)           hit_pend <= 1'b1;
            else if (frame_tick) hit_pend <= 1'b0;
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                     rclick_pend <= 1'b0;
        else if (pulse[IDX_RIGHT])      rclick_pend <= 1'b1;
        else if (frame_tick)            rclick_pend <= 1'b0;
    end
`endif

    // State register; mode outputs are registered alongside it so they stay one-hot and glitch-free.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state           <= ST_START;
            start_signal    <= 1'b1;
            ingame_signal   <= 1'b0;
            gameover_signal <= 1'b0;
`ifdef GAME_PAUSE_EN
            paused          <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            start_signal    <= start_d;
            ingame_signal   <= ingame_d;
            gameover_signal <= gameover_d;
`ifdef GAME_PAUSE_EN
            paused          <= paused_d;
`endif
        end
    end

    // Transitions happen only on a frame tick so the mapper never switches screens mid-frame.
    // NOTE: default assignment first keeps this combinational block free of inferred latches.
    always_comb begin
        state_d = state;
        if (frame_tick) begin
            case (state)
                ST_START:    if (click_pend) state_d = ST_INGAME;
                ST_INGAME: begin
`ifdef GAME_PAUSE_EN
                    if (pause_req) state_d = ST_PAUSE;
                    else
`endif
                    if (hit_pend && !invuln && lives == 3'd1) state_d = ST_GAMEOVER;
                end
                ST_GAMEOVER: if (hold_cnt == 8'd0 && click_pend) state_d = ST_START;
`ifdef GAME_PAUSE_EN
                ST_PAUSE:    if (pause_req) state_d = ST_INGAME;
`endif
                default:     state_d = ST_START;
            endcase
        end
    end

    always_comb begin
        start_d    = (state_d == ST_START);
        gameover_d = (state_d == ST_GAMEOVER);
`ifdef GAME_PAUSE_EN
        paused_d   = (state_d == ST_PAUSE);
        ingame_d   = (state_d == ST_INGAME) || (state_d == ST_PAUSE);
`else
        ingame_d   = (state_d == ST_INGAME);
`endif
    end

    // Lives, score and the two frame counters; a pause request on a tick freezes everything.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lives    <= LIVES_LD;
            score    <= '0;
            invuln   <= 1'b0;
            inv_cnt  <= 8'd0;
            hold_cnt <= 8'd0;
        end else begin
            if (state == ST_INGAME && eat_p && score != '1) score <= score + SCORE_W'(1);

            if (frame_tick) begin
                case (state)
                    ST_START: begin
                        if (click_pend) begin
                            lives   <= LIVES_LD;
                            score   <= '0;
                            invuln  <= 1'b0;
                            inv_cnt <= 8'd0;
                        end
                    end
                    ST_INGAME: begin
                        if (!pause_req) begin
                            if (hit_pend && !invuln) begin
                                if (lives == 3'd1) begin
                                    lives    <= 3'd0;
                                    hold_cnt <= HOLD_LD;
                                end else begin
                                    lives   <= lives - 3'd1;
                                    invuln  <= 1'b1;
                                    inv_cnt <= INV_LD;
                                end
                            end else if (invuln) begin
                                if (inv_cnt <= 8'd1) begin
                                    inv_cnt <= 8'd0;
                                    invuln  <= 1'b0;
                                end else begin
                                    inv_cnt <= inv_cnt - 8'd1;
                                end
                            end
                        end
                    end
                    ST_GAMEOVER: begin
                        if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Directed bench for game_mode_ctrl: expectations are queued as stimulus is driven and
// compared with immediate assertions once the DUT has had time to respond.
module tb_game_mode_ctrl;

    localparam int SW = 8;
    localparam logic [2:0] M_START = 3'b100;
    localparam logic [2:0] M_ING   = 3'b010;
    localparam logic [2:0] M_GO    = 3'b001;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          frame_clk = 1'b0, leftButton = 1'b0, rightButton = 1'b0;
    logic          hit = 1'b0, eat = 1'b0;
    logic          start_signal, ingame_signal, gameover_signal, invuln;
    logic [2:0]    lives;
    logic [SW-1:0] score;
`ifdef GAME_PAUSE_EN
    logic          paused;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [2:0] mode;
        logic [2:0] lives;
        logic [7:0] score;
        logic       inv;
    } exp_t;

    exp_t sb[$];

    game_mode_ctrl #(.LIVES_INIT(3), .INVULN_FRAMES(60), .GO_HOLD_FRAMES(120), .SCORE_W(SW)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .leftButton(leftButton), .rightButton(rightButton), .hit(hit), .eat(eat),
        .start_signal(start_signal), .ingame_signal(ingame_signal), .gameover_signal(gameover_signal),
        .lives(lives), .score(score), .invuln(invuln)
`ifdef GAME_PAUSE_EN
        , .paused(paused)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] mode, input int lv, input int sc, input logic inv);
        exp_t e;
        e.tag   = tag;
        e.mode  = mode;
        e.lives = 3'(lv);
        e.score = 8'(sc);
        e.inv   = inv;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".mode"},   32'({start_signal, ingame_signal, gameover_signal}), 32'(e.mode));
            cmp({e.tag, ".lives"},  32'(lives),  32'(e.lives));
            cmp({e.tag, ".score"},  32'(score),  32'(e.score));
            cmp({e.tag, ".invuln"}, 32'(invuln), 32'(e.inv));
        end
    endtask

    // Two-cycle pulse on any combination of the level inputs, then two idle cycles.
    task automatic pulse(input logic l, input logic r, input logic h, input logic e);
        leftButton = l; rightButton = r; hit = h; eat = e;
        repeat (2) step();
        leftButton = 1'b0; rightButton = 1'b0; hit = 1'b0; eat = 1'b0;
        repeat (2) step();
    endtask

    task automatic frame(input string tag, input logic [2:0] mode, input int lv, input int sc, input logic inv);
        push(tag, mode, lv, sc, inv);
        frame_clk = 1'b1;
        repeat (4) step();
        drain();
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    // Sixty frames after a hit: invuln must stay high through frame 59 and drop on frame 60.
    task automatic inv_window(input string tag, input int hit_at, input int lv, input int sc);
        for (int k = 1; k <= 60; k++) begin
            if (k == hit_at) pulse(1'b0, 1'b0, 1'b1, 1'b0);
            frame($sformatf("%s_f%0d", tag, k), M_ING, lv, sc, k < 60);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        push("reset", M_START, 3, 0, 1'b0);
        drain();
`ifdef GAME_PAUSE_EN
        cmp("reset.paused", 32'(paused), 32'd0);
`endif
        Reset = 1'b1;
        repeat (2) step();

        // Click without a frame edge does nothing; mode changes exactly 4 Clk after frame_clk rises
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        push("click_no_frame", M_START, 3, 0, 1'b0);
        drain();
        push("lat3", M_START, 3, 0, 1'b0);
        frame_clk = 1'b1;
        repeat (3) step();
        drain();
        push("lat4", M_ING, 3, 0, 1'b0);
        step();
        drain();
        frame_clk = 1'b0;
        repeat (4) step();

        // Eat scoring is immediate in INGAME
        repeat (5) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        push("eat5", M_ING, 3, 5, 1'b0);
        drain();

        // Hit on frame N, second hit at N+10 is discarded, invuln drops at N+60
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        frame("hit1", M_ING, 2, 5, 1'b1);
        inv_window("win1", 10, 2, 5);

        // Hit and eat on the same Clk are both applied
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        push("hit_eat_score", M_ING, 2, 6, 1'b0);
        drain();
        frame("hit_eat_frame", M_ING, 1, 6, 1'b1);

        // Asynchronous reset mid-game with lives=1 and invuln=1
        step();
        #2 Reset = 1'b0;
        #1;
        push("async_reset", M_START, 3, 0, 1'b0);
        drain();
        step();
        Reset = 1'b1;
        repeat (2) step();

        // Eat ignored outside INGAME, then start a fresh game
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        push("eat_in_start", M_START, 3, 0, 1'b0);
        drain();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        frame("start2", M_ING, 3, 0, 1'b0);

        // Score saturates at all-ones
        repeat (255) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        push("sat255", M_ING, 3, 255, 1'b0);
        drain();
        repeat (5) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        push("sat_hold", M_ING, 3, 255, 1'b0);
        drain();

        // Three hits spaced past the invulnerability window: 3 -> 2 -> 1 -> 0, then GAMEOVER
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        frame("g_hit1", M_ING, 2, 255, 1'b1);
        inv_window("g_win1", 0, 2, 255);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        frame("g_hit2", M_ING, 1, 255, 1'b1);
        inv_window("g_win2", 0, 1, 255);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        frame("g_hit3", M_GO, 0, 255, 1'b0);

        // Game-over hold: clicks during the 120 hold frames are ignored, click at frame 121 returns to START
        for (int k = 1; k <= 120; k++) begin
            if (k == 50 || k == 120) pulse(1'b1, 1'b0, 1'b0, 1'b0);
            frame($sformatf("hold_f%0d", k), M_GO, 0, 255, 1'b0);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        frame("hold_exit", M_START, 0, 255, 1'b0);

`ifdef GAME_PAUSE_EN
        // Pause: hits and eats ignored while paused, second right click resumes play
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        frame("p_start", M_ING, 3, 0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        frame("p_enter", M_ING, 3, 0, 1'b0);
        cmp("p_enter.paused", 32'(paused), 32'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        push("p_eat", M_ING, 3, 0, 1'b0);
        drain();
        frame("p_hit", M_ING, 3, 0, 1'b0);
        cmp("p_hit.paused", 32'(paused), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        frame("p_exit", M_ING, 3, 0, 1'b0);
        cmp("p_exit.paused", 32'(paused), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        frame("p_hit_after", M_ING, 2, 0, 1'b1);
`endif

        cmp("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_mode_ctrl.md
Name: game_mode_ctrl

Overview:
- Top-level game sequencer that drives the color mapper's mode inputs (start_signal, ingame_signal, gameover_signal) plus lives, score and invulnerability status.
- Consumes mouse buttons and collision/eat pulses from the ball logic.
- Mode changes are committed only on frame boundaries, so the mapper never switches screens mid-frame.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..7).
- INVULN_FRAMES, 60, frames after a hit during which further hits are ignored.
- GO_HOLD_FRAMES, 120, frames the game-over screen ignores clicks.
- SCORE_W, 16, score counter width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame-rate strobe (vsync-derived), asynchronous to Clk
- leftButton  in  1  mouse left button level
- rightButton  in  1  mouse right button level
- hit  in  1  player-ball collision level (from ball logic)
- eat  in  1  player ate a food ball, level
- start_signal  out  1  start screen active
- ingame_signal  out  1  gameplay active
- gameover_signal  out  1  game-over screen active
- lives  out  3  remaining lives
- score  out  SCORE_W  food eaten this game
- invuln  out  1  high during invulnerability window (mapper may blink the player)

Behaviour:
- Reset low (async): state=START; start_signal=1, other modes 0; lives=LIVES_INIT; score=0; invuln=0; all counters, latches and synchronizers cleared. Reset mid-game returns to START immediately.
- Synchronizers: frame_clk, leftButton, rightButton, hit and eat each pass through a 2-flop synchronizer.
- Edge detection: rising-edge detect gives one-Clk pulses frame_tick, lclick, rclick, hit_p, eat_p.
- Pending latches: lclick and hit_p set sticky flags click_pend and hit_pend. Both are consumed and cleared on frame_tick.
- Simultaneous events: a set and a clear on the same cycle resolve to set, and the pending event carries to the next frame.
- Eat scoring: eat_p increments score immediately in INGAME only, saturating at all-ones. Eat is ignored in other states.
- START state: on frame_tick with click_pend, go to INGAME; lives=LIVES_INIT, score=0, invuln=0.
- INGAME state, on each frame_tick:
  - If hit_pend and invuln=0: lives decrements. If lives was 1, lives goes to 0, the state goes to GAMEOVER and hold_cnt loads GO_HOLD_FRAMES. Otherwise invuln=1 and inv_cnt loads INVULN_FRAMES.
  - If invuln=1: inv_cnt decrements; invuln clears on the tick where inv_cnt reaches 0.
  - Hits during invuln are discarded.
  - click_pend is discarded.
- GAMEOVER state: hold_cnt decrements on each frame_tick until 0. Click latches are cleared while hold_cnt≠0. When hold_cnt=0 and click_pend is set at a frame_tick, go to START; score is retained until the next game start.
- Outputs: mode outputs are registered and exactly one-hot at all times. They update on the Clk cycle after the frame_tick that commits the transition. Latency from frame_clk rising edge to mode change is 4 Clk cycles (2 sync + 1 edge + 1 register).
- Counters: inv_cnt and hold_cnt are 8 bits wide and saturate at 0 (no wrap).

Optional Feature:
- Macro: GAME_PAUSE_EN.
- When defined:
  - Adds a PAUSE state.
  - In INGAME, rclick latched to a frame_tick moves the state to PAUSE. An rclick in PAUSE at a frame_tick returns to INGAME.
  - During PAUSE: ingame_signal=1 (screen stays drawn), eat and hit are ignored, and inv_cnt is frozen.
  - Adds output paused (1 bit, reset 0).
- When not defined: rightButton is unused, there is no PAUSE state and no paused port.

Test Plan:
- Reset low then release, then leftButton pulse → start_signal stays 1 until the next frame_clk edge. ingame_signal rises 4 Clk after that edge; lives=3, score=0.
- INGAME, three hit pulses on separate frames each spaced >60 frames apart → lives 3→2→1→0. gameover_signal=1 after the third hit's frame; invuln=1 for exactly 60 frames after each of the first two hits.
- Hit on frame N, second hit on frame N+10 → lives=2 only; invuln falls at frame N+60.
- GAMEOVER, leftButton at frame 50 of hold → ignored. Click at frame 121 → start_signal=1 on the next frame; score still holds its last value.
- eat pulse 70000 times in INGAME (SCORE_W=16) → score saturates at 16'hFFFF. hit and eat on the same Clk → both applied.
- Assert Reset mid-INGAME with lives=1 and invuln=1 → outputs return to start_signal=1, lives=3, score=0, invuln=0 asynchronously. With GAME_PAUSE_EN defined: rclick in INGAME → paused=1 and hits are ignored; a second rclick → paused=0.
